// File: rtl/serial_add_sequencer_if.sv
// Handshake and data bus for serial_add_sequencer.
// SERIAL_ADD_SUB_EN adds the sub request line alongside the operands.
interface serial_add_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operations, observes status and result
  modport master (
    output start, a, b,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  // Sequencer side
  modport slave (
    input  start, a, b,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-add cell (two half-add stages) reused LSB first,
// one bit per clock, with start/busy/done handshake.
// Optional SERIAL_ADD_SUB_EN: sub request computes a-b via ~b and carry-in 1.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_add_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             carry_d;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             p;
  logic             g;
  logic             s;
  logic             carry_init;
  logic [WIDTH-1:0] opb_init;

  // Full-add cell on the current LSBs; result shifts in at the MSB
  always_comb begin
    p              = opa_q[0] ^ opb_q[0];
    g              = opa_q[0] & opb_q[0];
    s              = p ^ carry_q;
    carry_d        = g | (p & carry_q);
    res_d          = res_q >> 1;
    res_d[WIDTH-1] = s;
  end

  // Operand B and carry-in as loaded on an accepted start
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    carry_init = bus.sub;
    opb_init   = bus.sub ? ~bus.b : bus.b;
`else
    carry_init = 1'b0;
    opb_init   = bus.b;
`endif
  end

  // Sequencer FSM with datapath and registered status/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            opa_q   <= bus.a;
            opb_q   <= opb_init;
            carry_q <= carry_init;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          res_q   <= res_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            sum_q   <= res_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: driver pushes expected results
// computed arithmetically; a negedge monitor checks busy/done/sum/cout.
module tb_serial_add_sequencer;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errs;
  int   checks;
  exp_t q[$];
  logic [W-1:0] last_sum;
  logic         last_cout;

  serial_add_sequencer_if #(.WIDTH(W)) bus ();

  serial_add_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: expected status derived from the accept cycle of the oldest op
  always @(negedge clk) begin
    logic exp_busy;
    logic exp_done;
    if (rst_n) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (q.size() > 0) begin
        exp_busy = (cyc >= q[0].acc) && (cyc < q[0].acc + int'(W));
        exp_done = (cyc == q[0].acc + int'(W));
      end
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      if (exp_done) begin
        last_sum  = q[0].s;
        last_cout = q[0].c;
        void'(q.pop_front());
      end
      chk("sum", 32'(bus.sum), 32'(last_sum));
      chk("cout", 32'(bus.cout), 32'(last_cout));
    end
  end

  // Wait for IDLE, request one op, record expected result and accept cycle
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sb, input bit hold);
    int n;
    logic [W:0] t;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(bus.busy === 1'b0 && bus.done === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errs++;
      checks++;
      $display("FAIL idle_wait: got busy=%0b done=%0b expected idle", bus.busy, bus.done);
      return;
    end
    #1;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = sb;
`endif
    if (sb) begin
      t   = {1'b0, av} - {1'b0, bv};
      e.s = t[W-1:0];
      e.c = (av >= bv);
    end else begin
      t   = {1'b0, av} + {1'b0, bv};
      e.s = t[W-1:0];
      e.c = t[W];
    end
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    if (!hold) begin
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_sum"},  32'(bus.sum),  32'd0);
    chk({tag, "_cout"}, 32'(bus.cout), 32'd0);
  endtask

  initial begin
    int n;
    errs      = 0;
    checks    = 0;
    cyc       = 0;
    last_sum  = '0;
    last_cout = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors
    do_op(8'h03, 8'h05, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);

    // Start held high: back-to-back restarts every W+2 cycles
    for (int i = 0; i < 3; i++) do_op(8'h10, 8'h20, 1'b0, 1'b1);
    bus.start = 1'b0;

    // Start pulsed during RUN must be ignored
    do_op(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;

    // Abort mid-RUN via asynchronous reset
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.a = 8'hC3;
    bus.b = 8'h3C;
    #2 rst_n = 1'b0;
    q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    do_op(8'h02, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h05, 8'h03, 1'b1, 1'b0);
    do_op(8'h03, 8'h05, 1'b1, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 1'b0);
    do_op(8'h44, 8'h44, 1'b1, 1'b0);
`endif

    // Randomized operations
    for (int i = 0; i < 25; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`else
      do_op(W'($urandom), W'($urandom), 1'b0, 1'b0);
`endif
    end

    // Drain outstanding results
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial adder controller. It time-shares one full-add cell, built from two half-add stages, across all bits of a WIDTH-bit operand pair, LSB first, one bit per clock.
- Start/busy/done handshake.
- Sits behind the tt_um top-level pin wrapper, trading the parallel half-adder datapath for a multi-bit add at one bit-cell of logic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1 to 16.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result, registered; holds until the next accepted start completes.
- cout  output  1  final carry out, registered.
- sub  input  1  only present with SERIAL_ADD_SUB_EN; see Optional Feature.

Behaviour:
- Reset: one clock, asynchronous active-low reset, ports named clk and rst_n. While rst_n=0, regardless of clk:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry and counter = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge → latch a into opa and b into opb, carry=0, cnt=0, go to RUN.
  - start=0 → stay.
- RUN, each cycle:
  - Stage 1: p = opa[0]^opb[0], g = opa[0]&opb[0].
  - Stage 2: s = p^carry, carry_next = g | (p&carry).
  - opa and opb shift right by 1.
  - Result shift register shifts right, with s entering at bit WIDTH-1.
  - cnt increments.
  - When cnt == WIDTH-1 at the edge, go to DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- DONE (one cycle):
  - sum = completed result shift register, cout = final carry; both loaded on the RUN→DONE edge.
  - done=1 during this cycle; next edge → IDLE.
- busy = (state==RUN), registered. done = (state==DONE).
- sum/cout update only on the RUN→DONE edge; they are stable during a following RUN.
- Latency: start sampled at edge k → busy high from k to k+WIDTH → done high from edge k+WIDTH to k+WIDTH+1.
- Back-to-back: start held high restarts on the first IDLE edge. Period is WIDTH+2 cycles.
- start while in RUN or DONE is ignored; it is not queued.
- a/b changes after acceptance have no effect.
- WIDTH=1: RUN lasts one cycle; behaves as a registered full-add of the two bits.
- Reset mid-RUN aborts the operation:
  - the partial result is discarded, sum/cout clear to 0, no done pulse;
  - after rst_n deasserts, the first start is accepted normally.
- Arithmetic: sum = (a+b) mod 2**WIDTH; cout = bit WIDTH of a+b.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - adds input sub, latched with a/b on accepted start;
  - sub=1: opb is loaded as ~b and carry initialises to 1, so sum = (a-b) mod 2**WIDTH and cout = 1 when a>=b (no borrow);
  - sub=0: identical to add.
- Undefined: no sub port; carry always initialises to 0; add only.

Test Plan:
- WIDTH=8, reset, start with a=8'h03, b=8'h05 for one cycle → busy high 8 cycles; done single pulse exactly 8 edges after acceptance; sum=8'h08, cout=0.
- a=8'hFF, b=8'h01 → sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A → sum=8'hFF, cout=0.
- start held high continuously with a=8'h10, b=8'h20 → done pulses every 10 cycles, each with sum=8'h30. Pulse start again during busy → no extra op, no extra done.
- Start a=8'h7F, b=8'h01; change a/b mid-RUN; assert rst_n=0 at RUN cycle 4 → outputs 0 immediately (asynchronous), no done. Release, start 8'h02+8'h02 → sum=8'h04.
- With SERIAL_ADD_SUB_EN: 8'h05-8'h03 → sum=8'h02, cout=1; 8'h03-8'h05 → sum=8'hFE, cout=0; sub=0 with 8'h03+8'h05 → 8'h08.
- WIDTH=1 build: a=1, b=1 → done after 1 RUN cycle, sum=0, cout=1.
